// File: rtl/vfd_ramp_ctrl.sv
// vfd_ramp_ctrl: soft-start/soft-stop ramp of a half-period divider terminal count driving clk_out
module vfd_ramp_ctrl #(
    parameter int CNT_W = 13,
    parameter int RP_W  = 16
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] target_lim,
    input  logic [CNT_W-1:0] start_lim,
    input  logic [CNT_W-1:0] ramp_step,
    input  logic [RP_W-1:0]  ramp_period,
    output logic             clk_out,
    output logic [CNT_W-1:0] cur_lim,
    output logic [1:0]       state,
    output logic             at_speed,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cur_lim_q, cur_lim_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic [CNT_W-1:0] strt_q, strt_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [RP_W-1:0]  rcnt_q, rcnt_d;
    logic             stopping_q, stopping_d;
    logic             clk_out_q, clk_out_d;
    logic             at_speed_q, busy_q;

    logic [CNT_W-1:0] step;
    logic [CNT_W-1:0] dest;
    logic [CNT_W:0]   up_sum;
    logic [CNT_W:0]   dn_sum;
    logic             ramping;
    logic             tick;
    logic             stop_ok;
    logic             start_ok;

    // Ramp tick, effective step and the widened sums used for wrap-free limit compares
    always_comb begin
        step     = (ramp_step == '0) ? CNT_W'(1) : ramp_step;
        ramping  = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
        tick     = ramping && (rcnt_q == ramp_period);
        dest     = stopping_q ? strt_q : tgt_q;
        up_sum   = {1'b0, tgt_q} + {1'b0, step};
        dn_sum   = {1'b0, cur_lim_q} + {1'b0, step};
        stop_ok  = stop && (state_q != IDLE) && !(stopping_q && (state_q == RAMP_DOWN));
        start_ok = start && !stop;
    end

    // Sequencer: commands take priority over ramp ticks, stop beats start, IDLE entry zeroes the limit
    always_comb begin
        state_d    = state_q;
        cur_lim_d  = cur_lim_q;
        tgt_d      = tgt_q;
        strt_d     = strt_q;
        stopping_d = stopping_q;
        if (stop_ok) begin
            stopping_d = 1'b1;
            state_d    = RAMP_DOWN;
        end else if (start_ok && (state_q == IDLE)) begin
            tgt_d     = target_lim;
            strt_d    = start_lim;
            cur_lim_d = start_lim;
            state_d   = (target_lim < start_lim) ? RAMP_UP :
                        (target_lim > start_lim) ? RAMP_DOWN : RUN;
        end else if (start_ok) begin
            stopping_d = 1'b0;
            tgt_d      = target_lim;
            state_d    = (target_lim < cur_lim_q) ? RAMP_UP :
                         (target_lim > cur_lim_q) ? RAMP_DOWN : RUN;
        end else if (tick && (state_q == RAMP_UP)) begin
            cur_lim_d = ({1'b0, cur_lim_q} <= up_sum) ? tgt_q : cur_lim_q - step;
            state_d   = ({1'b0, cur_lim_q} <= up_sum) ? RUN : RAMP_UP;
        end else if (tick) begin
            cur_lim_d = (dn_sum >= {1'b0, dest}) ? dest : dn_sum[CNT_W-1:0];
            state_d   = (dn_sum < {1'b0, dest}) ? RAMP_DOWN : stopping_q ? IDLE : RUN;
        end
        if (state_d == IDLE) begin
            cur_lim_d  = '0;
            stopping_d = 1'b0;
        end
    end

    // Ramp period counter restarts on any state change and after each tick
    always_comb begin
        rcnt_d = ((state_d != state_q) || !ramping || tick) ? '0 : rcnt_q + 1'b1;
    end

    // Half-period divider; held cleared while idle or entering idle, >= tolerates a shrinking limit
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        clk_out_d = clk_out_q;
        if ((state_q == IDLE) || (state_d == IDLE)) begin
            div_cnt_d = '0;
            clk_out_d = 1'b0;
        end else if (div_cnt_q >= cur_lim_q) begin
            div_cnt_d = '0;
            clk_out_d = ~clk_out_q;
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cur_lim_q  <= '0;
            tgt_q      <= '0;
            strt_q     <= '0;
            div_cnt_q  <= '0;
            rcnt_q     <= '0;
            stopping_q <= 1'b0;
            clk_out_q  <= 1'b0;
            at_speed_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_lim_q  <= cur_lim_d;
            tgt_q      <= tgt_d;
            strt_q     <= strt_d;
            div_cnt_q  <= div_cnt_d;
            rcnt_q     <= rcnt_d;
            stopping_q <= stopping_d;
            clk_out_q  <= clk_out_d;
            at_speed_q <= (state_d == RUN);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign clk_out  = clk_out_q;
    assign cur_lim  = cur_lim_q;
    assign state    = state_q;
    assign at_speed = at_speed_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_vfd_ramp_ctrl.sv
// tb_vfd_ramp_ctrl: directed checks of ramp sequencing, divider timing, stop/retarget and reset
module tb_vfd_ramp_ctrl;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [12:0] target_lim;
    logic [12:0] start_lim;
    logic [12:0] ramp_step;
    logic [15:0] ramp_period;
    logic        clk_out;
    logic [12:0] cur_lim;
    logic [1:0]  state;
    logic        at_speed;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int half;

    vfd_ramp_ctrl dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .target_lim (target_lim),
        .start_lim  (start_lim),
        .ramp_step  (ramp_step),
        .ramp_period(ramp_period),
        .clk_out    (clk_out),
        .cur_lim    (cur_lim),
        .state      (state),
        .at_speed   (at_speed),
        .busy       (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic expect_st(input string tag, input int st, input int lim, input int bsy, input int spd);
        check({tag, ".state"}, state, st);
        check({tag, ".cur_lim"}, cur_lim, lim);
        check({tag, ".busy"}, busy, bsy);
        check({tag, ".at_speed"}, at_speed, spd);
    endtask

    task automatic pulse(input logic sa, input logic so);
        start = sa;
        stop  = so;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic measure_half(output int n);
        logic p;
        int   k;
        p = clk_out;
        k = 0;
        while (clk_out == p && k < 100) begin
            step(1);
            k++;
        end
        p = clk_out;
        n = 0;
        while (clk_out == p && n < 100) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        target_lim  = 13'd10;
        start_lim   = 13'd20;
        ramp_step   = 13'd3;
        ramp_period = 16'd4;
        step(2);
        expect_st("reset", 0, 0, 0, 0);
        check("reset.clk_out", clk_out, 0);
        reset = 1'b1;
        step(2);

        pulse(1'b1, 1'b0);
        expect_st("up0", 1, 20, 1, 0);
        step(5);
        expect_st("up1", 1, 17, 1, 0);
        step(5);
        expect_st("up2", 1, 14, 1, 0);
        step(5);
        expect_st("up3", 1, 11, 1, 0);
        step(5);
        expect_st("up4", 2, 10, 1, 1);
        measure_half(half);
        check("run.half_period", half, 11);

        pulse(1'b0, 1'b1);
        expect_st("stop0", 3, 10, 1, 0);
        step(5);
        check("stop1.cur_lim", cur_lim, 13);
        step(5);
        check("stop2.cur_lim", cur_lim, 16);
        step(5);
        expect_st("stop3", 3, 19, 1, 0);
        step(5);
        expect_st("stop_idle", 0, 0, 0, 0);
        check("stop_idle.clk_out", clk_out, 0);

        pulse(1'b1, 1'b0);
        step(10);
        expect_st("mid_up", 1, 14, 1, 0);
        pulse(1'b0, 1'b1);
        expect_st("mid_stop0", 3, 14, 1, 0);
        step(5);
        expect_st("mid_stop1", 3, 17, 1, 0);
        step(5);
        expect_st("mid_idle", 0, 0, 0, 0);

        pulse(1'b1, 1'b0);
        step(20);
        expect_st("rt_run", 2, 10, 1, 1);
        target_lim = 13'd15;
        pulse(1'b1, 1'b0);
        expect_st("rt0", 3, 10, 1, 0);
        step(5);
        expect_st("rt1", 3, 13, 1, 0);
        step(5);
        expect_st("rt2", 2, 15, 1, 1);

        target_lim = 13'd5;
        pulse(1'b1, 1'b1);
        expect_st("both0", 3, 15, 1, 0);
        step(5);
        expect_st("both1", 3, 18, 1, 0);
        step(5);
        expect_st("both_idle", 0, 0, 0, 0);

        target_lim  = 13'd3;
        start_lim   = 13'd5;
        ramp_step   = 13'd0;
        ramp_period = 16'd0;
        pulse(1'b1, 1'b0);
        expect_st("s0_up0", 1, 5, 1, 0);
        step(1);
        expect_st("s0_up1", 1, 4, 1, 0);
        step(1);
        expect_st("s0_run", 2, 3, 1, 1);
        pulse(1'b0, 1'b1);
        expect_st("s0_dn0", 3, 3, 1, 0);
        step(1);
        expect_st("s0_dn1", 3, 4, 1, 0);
        step(1);
        expect_st("s0_idle", 0, 0, 0, 0);

        target_lim = 13'd12;
        start_lim  = 13'd8;
        ramp_step  = 13'd3;
        pulse(1'b1, 1'b0);
        expect_st("slow0", 3, 8, 1, 0);
        step(1);
        expect_st("slow1", 3, 11, 1, 0);
        step(1);
        expect_st("slow_run", 2, 12, 1, 1);
        pulse(1'b0, 1'b1);
        step(1);
        expect_st("slow_idle", 0, 0, 0, 0);

        target_lim = 13'd6;
        start_lim  = 13'd6;
        pulse(1'b1, 1'b0);
        expect_st("eq_run", 2, 6, 1, 1);
        step(6);
        check("eq.clk_out_low", clk_out, 0);
        step(1);
        check("eq.clk_out_rise", clk_out, 1);
        pulse(1'b0, 1'b1);
        step(1);
        expect_st("eq_idle", 0, 0, 0, 0);
        check("eq_idle.clk_out", clk_out, 0);

        target_lim  = 13'd10;
        start_lim   = 13'd20;
        ramp_period = 16'd4;
        pulse(1'b1, 1'b0);
        step(5);
        expect_st("rst_pre", 1, 17, 1, 0);
        #3;
        reset = 1'b0;
        #1;
        expect_st("rst_async", 0, 0, 0, 0);
        check("rst_async.clk_out", clk_out, 0);
        #2;
        reset = 1'b1;
        step(30);
        expect_st("rst_after", 0, 0, 0, 0);
        check("rst_after.clk_out", clk_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
